hl1_step_scheduler: RTL and testbench

//  Sequences the N hidden-layer-1 output neurons through each time unit (TU) of an image.
//  - Broadcasts isor_0_start / isor_1_start and the li level.
//  - Arbitrates lateral inhibition: gathers start_li from all neurons and returns one winner.
//  - Collects valid_nu / spike_op_nu and pulses TU_incre.
//  - Sits between the input-spike front end and the neuron array; it drives start_core_img
//    and the per-TU handshake.

---
 rtl/hl1_step_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_hl1_step_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hl1_step_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hl1_step_scheduler                                           |
// | Description : Per-TU sequencer for the hidden-layer-1 neuron array:        |
// |               step handshake, isor start broadcast, lateral-inhibition     |
// |               arbitration, and completion/TU advance.                      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module hl1_step_scheduler #(
  parameter int N      = 8,
  parameter int W      = 24,
  parameter int TH     = 15018,
  parameter int TSTEPS = 350
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_start_img,
  input  logic           i_step_req,
  input  logic           i_ip_spike_any,
  output logic           o_step_ack,
  output logic           o_start_core_img,
  output logic           o_isor_0_start,
  output logic           o_isor_1_start,
  output logic           o_li,
  input  logic [N-1:0]   i_start_li,
  input  logic [N*W-1:0] i_potential,
  output logic           o_valid_li,
  output logic [N-1:0]   o_won_lost,
  input  logic [N-1:0]   i_valid_nu,
  input  logic [N-1:0]   i_spike_op_nu,
  output logic           o_TU_incre,
  output logic [N-1:0]   o_spike_vec,
  output logic [15:0]    o_tu_count,
  output logic           o_img_done
);

  localparam int                    IW   = (N > 1) ? $clog2(N) : 1;
  localparam logic signed [W-1:0]   C_TH = W'(TH);
  localparam logic [15:0]           C_LAST_TU = 16'(TSTEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_STEP = 3'd1,
    S_ISSUE     = 3'd2,
    S_COLLECT   = 3'd3,
    S_LI_SCAN   = 3'd4,
    S_LI_REPLY  = 3'd5,
    S_ADVANCE   = 3'd6
  } state_t;

  state_t                r_state, w_state_n;
  logic                  r_spike;
  logic                  r_start_core;
  logic                  r_li;
  logic [N-1:0]          r_done, r_shadow, r_req;
  logic [N-1:0]          r_won_lost, r_spike_vec;
  logic [15:0]           r_tu_count;
  logic [IW-1:0]         r_scan_idx, r_best_idx;
  logic signed [W-1:0]   r_best;

  logic [N-1:0]          w_done_n, w_shadow_n, w_req_n, w_onehot;
  logic signed [W-1:0]   w_cand, w_best_n;
  logic [IW-1:0]         w_idx_n;
  logic                  w_scan_last, w_last_tu;

  // Sticky masks: a neuron's first completion pulse owns its spike bit; repeats are ignored.
  always_comb begin
    w_done_n   = r_done | i_valid_nu;
    w_shadow_n = r_shadow | (i_spike_op_nu & i_valid_nu & ~r_done);
    w_req_n    = r_req | (i_start_li & {N{~r_li}});
  end

  // Running signed maximum over the scan; strict > keeps the lowest index on ties.
  always_comb begin
    w_cand      = i_potential[int'(r_scan_idx)*W +: W];
    w_best_n    = r_best;
    w_idx_n     = r_best_idx;
    if ((r_scan_idx == '0) || (w_cand > r_best)) begin
      w_best_n = w_cand;
      w_idx_n  = r_scan_idx;
    end
    w_onehot    = {{(N-1){1'b0}}, 1'b1} << w_idx_n;
    w_scan_last = (r_scan_idx == IW'(N-1));
    w_last_tu   = (r_tu_count == C_LAST_TU);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_n;
  end

  // Next-state and per-state output decode; start_img overrides everything.
  always_comb begin
    w_state_n      = r_state;
    o_step_ack     = 1'b0;
    o_isor_0_start = 1'b0;
    o_isor_1_start = 1'b0;
    o_valid_li     = 1'b0;
    o_TU_incre     = 1'b0;
    o_img_done     = 1'b0;
    o_spike_vec    = r_spike_vec;
    case (r_state)
      S_IDLE: ;
      S_WAIT_STEP: begin
        o_step_ack = i_step_req & ~i_start_img;
        if (i_step_req) w_state_n = S_ISSUE;
      end
      S_ISSUE: begin
        o_isor_1_start = r_spike;
        o_isor_0_start = ~r_spike;
        w_state_n      = S_COLLECT;
      end
      S_COLLECT: begin
        if ((&w_req_n) && !r_li) w_state_n = S_LI_SCAN;
        else if (&w_done_n)      w_state_n = S_ADVANCE;
      end
      S_LI_SCAN: begin
        if (w_scan_last) w_state_n = S_LI_REPLY;
      end
      S_LI_REPLY: begin
        o_valid_li = 1'b1;
        w_state_n  = S_COLLECT;
      end
      S_ADVANCE: begin
        o_TU_incre  = 1'b1;
        o_img_done  = w_last_tu;
        o_spike_vec = r_shadow;
        w_state_n   = w_last_tu ? S_IDLE : S_WAIT_STEP;
      end
      default: w_state_n = S_IDLE;
    endcase
    if (i_start_img) w_state_n = S_WAIT_STEP;
  end

  // Datapath: masks, LI scan result, TU counter and held result vectors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spike      <= 1'b0;
      r_start_core <= 1'b0;
      r_li         <= 1'b0;
      r_done       <= '0;
      r_shadow     <= '0;
      r_req        <= '0;
      r_won_lost   <= '0;
      r_spike_vec  <= '0;
      r_tu_count   <= '0;
      r_scan_idx   <= '0;
      r_best_idx   <= '0;
      r_best       <= '0;
    end else begin
      r_start_core <= i_start_img;
      if (i_start_img) begin
        r_li       <= 1'b0;
        r_done     <= '0;
        r_shadow   <= '0;
        r_req      <= '0;
        r_tu_count <= '0;
        r_scan_idx <= '0;
      end else begin
        case (r_state)
          S_WAIT_STEP: begin
            if (i_step_req) r_spike <= i_ip_spike_any;
          end
          S_COLLECT: begin
            r_done     <= w_done_n;
            r_shadow   <= w_shadow_n;
            r_req      <= w_req_n;
            r_scan_idx <= '0;
          end
          // Completions keep being recorded during arbitration so no pulse is lost.
          S_LI_SCAN: begin
            r_done     <= w_done_n;
            r_shadow   <= w_shadow_n;
            r_best     <= w_best_n;
            r_best_idx <= w_idx_n;
            r_scan_idx <= r_scan_idx + 1'b1;
            if (w_scan_last) begin
              r_won_lost <= (w_best_n >= C_TH) ? w_onehot : '1;
              r_li       <= (w_best_n >= C_TH);
            end
          end
          S_LI_REPLY: begin
            r_done   <= w_done_n;
            r_shadow <= w_shadow_n;
            r_req    <= '0;
          end
          S_ADVANCE: begin
            r_spike_vec <= r_shadow;
            r_done      <= '0;
            r_shadow    <= '0;
            if (r_tu_count != 16'hFFFF) r_tu_count <= r_tu_count + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_start_core_img = r_start_core;
  assign o_li             = r_li;
  assign o_won_lost       = r_won_lost;
  assign o_tu_count       = r_tu_count;

endmodule
`default_nettype wire

// File: tb/tb_hl1_step_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_hl1_step_scheduler                                        |
// | Description : Directed, table-driven bench for hl1_step_scheduler.         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_hl1_step_scheduler;

  localparam int N = 8, W = 24, TH = 15018, TSTEPS = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           i_start_img, i_step_req, i_ip_spike_any;
  logic           o_step_ack, o_start_core_img, o_isor_0_start, o_isor_1_start, o_li;
  logic [N-1:0]   i_start_li;
  logic [N*W-1:0] i_potential;
  logic           o_valid_li;
  logic [N-1:0]   o_won_lost;
  logic [N-1:0]   i_valid_nu, i_spike_op_nu;
  logic           o_TU_incre;
  logic [N-1:0]   o_spike_vec;
  logic [15:0]    o_tu_count;
  logic           o_img_done;

  hl1_step_scheduler #(.N(N), .W(W), .TH(TH), .TSTEPS(TSTEPS)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_start_img(i_start_img), .i_step_req(i_step_req), .i_ip_spike_any(i_ip_spike_any),
    .o_step_ack(o_step_ack), .o_start_core_img(o_start_core_img),
    .o_isor_0_start(o_isor_0_start), .o_isor_1_start(o_isor_1_start), .o_li(o_li),
    .i_start_li(i_start_li), .i_potential(i_potential),
    .o_valid_li(o_valid_li), .o_won_lost(o_won_lost),
    .i_valid_nu(i_valid_nu), .i_spike_op_nu(i_spike_op_nu),
    .o_TU_incre(o_TU_incre), .o_spike_vec(o_spike_vec),
    .o_tu_count(o_tu_count), .o_img_done(o_img_done)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  int cnt_tu = 0;

  // Count TU_incre pulses away from the active edge.
  always @(negedge clk) if (o_TU_incre) cnt_tu++;

  typedef struct packed {
    logic [N*W-1:0] pot;
    logic [N-1:0]   won;
    logic           li;
  } li_vec_t;

  li_vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] pots(input int p0, p1, p2, p3, p4, p5, p6, p7);
    logic [N*W-1:0] v;
    v = {W'(p7), W'(p6), W'(p5), W'(p4), W'(p3), W'(p2), W'(p1), W'(p0)};
    return v;
  endfunction

  task automatic start_image;
    i_start_img = 1'b1;
    #1;
    cyc;
    i_start_img = 1'b0;
    #1;
    chk("start_core_img", 32'(o_start_core_img), 32'd1);
    chk("tu_count_after_start", 32'(o_tu_count), 32'd0);
    chk("li_after_start", 32'(o_li), 32'd0);
  endtask

  task automatic issue_tu(input logic spk);
    i_step_req     = 1'b1;
    i_ip_spike_any = spk;
    #1;
    chk("step_ack", 32'(o_step_ack), 32'd1);
    cyc;
    i_step_req     = 1'b0;
    i_ip_spike_any = 1'b0;
    #1;
    chk("isor_1_start", 32'(o_isor_1_start), 32'(spk));
    chk("isor_0_start", 32'(o_isor_0_start), 32'(!spk));
    cyc;
  endtask

  task automatic nu_pulse(input int i, input logic spk);
    i_valid_nu    = N'(1) << i;
    i_spike_op_nu = N'(spk) << i;
    cyc;
    i_valid_nu    = '0;
    i_spike_op_nu = '0;
  endtask

  task automatic chk_adv(input logic [N-1:0] spv, input logic done, input int tu);
    #1;
    chk("TU_incre", 32'(o_TU_incre), 32'd1);
    chk("spike_vec", 32'(o_spike_vec), 32'(spv));
    chk("img_done", 32'(o_img_done), 32'(done));
    cyc;
    #1;
    chk("TU_incre_single", 32'(o_TU_incre), 32'd0);
    chk("tu_count", 32'(o_tu_count), 32'(tu));
  endtask

  task automatic li_run(input li_vec_t v);
    int lat;
    i_potential = v.pot;
    i_start_li  = '1;
    cyc;
    i_start_li  = '0;
    lat = 1;
    #1;
    while (!o_valid_li && lat < 20) begin
      cyc;
      #1;
      lat++;
    end
    chk("li_latency", 32'(lat), 32'(N + 1));
    chk("won_lost", 32'(o_won_lost), 32'(v.won));
    chk("li", 32'(o_li), 32'(v.li));
    cyc;
    #1;
    chk("valid_li_single", 32'(o_valid_li), 32'd0);
    chk("won_lost_held", 32'(o_won_lost), 32'(v.won));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tu_before;
    logic [7:0] pat;
    vecs[0] = '{pot: pots(1000, 1000, 1000, 1000, 1000, 16000, 1000, 1000), won: 8'h20, li: 1'b1};
    vecs[1] = '{pot: pots(12000, 12000, 12000, 12000, 12000, 12000, 12000, 12000), won: 8'hFF, li: 1'b0};
    vecs[2] = '{pot: pots(1000, 1000, 20000, 1000, 1000, 1000, 20000, 1000), won: 8'h04, li: 1'b1};
    vecs[3] = '{pot: pots(500, 500, 500, 15018, 500, 500, 500, -20000), won: 8'h08, li: 1'b1};
    vecs[4] = '{pot: pots(-5, 15017, -5, -5, -5, -5, -5, -5), won: 8'hFF, li: 1'b0};

    rst_n = 1'b0;
    i_start_img = 1'b0; i_step_req = 1'b0; i_ip_spike_any = 1'b0;
    i_start_li = '0; i_potential = '0; i_valid_nu = '0; i_spike_op_nu = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pulses", 32'({o_step_ack, o_start_core_img, o_isor_0_start, o_isor_1_start,
                             o_li, o_valid_li, o_TU_incre, o_img_done}), 32'd0);
    chk("reset_won_lost", 32'(o_won_lost), 32'd0);
    chk("reset_spike_vec", 32'(o_spike_vec), 32'd0);
    chk("reset_tu_count", 32'(o_tu_count), 32'd0);
    rst_n = 1'b1;
    cyc;

    // Image 1, TU0: no input spikes, staggered completions, no output spikes.
    start_image;
    issue_tu(1'b0);
    for (int i = 0; i < N; i++) nu_pulse(i, 1'b0);
    chk_adv(8'h00, 1'b0, 1);

    // TU1: input spikes, LI winner neuron 5, spike pattern A5.
    issue_tu(1'b1);
    li_run(vecs[0]);
    pat = 8'hA5;
    for (int i = 0; i < N; i++) nu_pulse(i, pat[i]);
    chk_adv(8'hA5, 1'b0, 2);

    // TU2 (last): duplicate pulse from neuron 0 must not change its spike or double-count.
    tu_before = cnt_tu;
    issue_tu(1'b0);
    nu_pulse(0, 1'b1);
    nu_pulse(0, 1'b0);
    for (int i = 1; i < N; i++) nu_pulse(i, 1'b0);
    chk_adv(8'h01, 1'b1, 3);
    chk("tu_incre_count_dup", 32'(cnt_tu - tu_before), 32'd1);

    // Back in IDLE: step requests are not acknowledged.
    i_step_req = 1'b1;
    #1;
    chk("idle_no_ack", 32'(o_step_ack), 32'd0);
    cyc;
    #1;
    chk("idle_no_isor", 32'({o_isor_0_start, o_isor_1_start}), 32'd0);
    i_step_req = 1'b0;

    // LI table: each entry is a fresh image; the restart aborts the previous TU.
    tu_before = cnt_tu;
    for (int v = 0; v < 5; v++) begin
      start_image;
      issue_tu(1'b1);
      li_run(vecs[v]);
    end
    chk("abort_no_tu_incre", 32'(cnt_tu - tu_before), 32'd0);

    // Abort mid-COLLECT after a completed TU with a winner already declared.
    start_image;
    issue_tu(1'b0);
    for (int i = 0; i < N; i++) nu_pulse(i, 1'b0);
    chk_adv(8'h00, 1'b0, 1);
    issue_tu(1'b1);
    li_run(vecs[2]);
    for (int i = 0; i < 4; i++) nu_pulse(i, 1'b1);
    tu_before = cnt_tu;
    start_image;
    #1;
    chk("abort_tu_incre", 32'(o_TU_incre), 32'd0);
    issue_tu(1'b0);
    for (int i = 1; i < N; i++) nu_pulse(i, 1'b0);
    #1;
    chk("masks_cleared", 32'(o_TU_incre), 32'd0);
    chk("abort_no_tu_count", 32'(cnt_tu - tu_before), 32'd0);
    nu_pulse(0, 1'b0);
    chk_adv(8'h00, 1'b0, 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
